deskew_rx: RTL and testbench
============================

Name: deskew_rx

Overview:
Multi-lane receive deskew for the multi-lane PCS, placed after per-lane alignment-marker lock and before lane reorder/descramble. It measures per-lane skew from alignment-marker arrival and delays every lane to the slowest one using per-lane block buffers. It then continuously checks that markers stay aligned after lock. Generalised successor of the single-lane deskew: parametrised lane count, gearbox pause support, skew-overflow and misalignment detection, and a lock state machine.

Parameters:
LANE_N, 4, number of PCS lanes
BLOCK_W, 66, block width in bits
MAX_SKEW_BIT_N, 1856, max tolerated dynamic skew in bits
MAX_SKEW_BLOCK_N, (MAX_SKEW_BIT_N-BLOCK_W-1)/BLOCK_W (=27), buffer depth per lane in blocks
SKEW_CNT_W, $clog2(MAX_SKEW_BLOCK_N), per-lane skew counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
data_v_i  in  1  block valid on all lanes this cycle (low on gearbox pause)
am_v_i  in  LANE_N  alignment marker present on lane l this cycle (qualified by data_v_i)
am_lock_i  in  1  all lanes have alignment-marker lock
data_i  in  LANE_N*BLOCK_W  lane blocks, lane l at [l*BLOCK_W +: BLOCK_W]
data_v_o  out  1  deskewed blocks valid
am_v_o  out  1  aligned marker at output this cycle
data_o  out  LANE_N*BLOCK_W  deskewed lane blocks
lock_o  out  1  deskew locked
skew_err_o  out  1  one-cycle pulse: skew overflow or post-lock misalignment
skew_zero_o  out  LANE_N  lane l offset is zero (latest lane[s])

Behaviour:
- Reset: all outputs 0, state WAIT, counters/offsets/seen flags 0; buffer contents not reset.
- Buffer: per lane, BLOCK_W+1 bits wide (block plus am flag), depth MAX_SKEW_BLOCK_N; shifts only when data_v_i=1. Entry 0 = most recent block.
- Read: data_o lane l = buffer entry offset_q[l]. Latency = 1 + offset_q[l] valid cycles.
- States: WAIT, ALIGN, LOCKED.
- Any state: am_lock_i=0 -> WAIT next cycle; clear seen flags, counters, offsets.
- WAIT: first valid cycle with any am_v_i -> set seen for those lanes, counters 0. If all lanes are seen in that cycle -> LOCKED with all offsets 0; otherwise -> ALIGN.
- ALIGN, per valid cycle:
  - Seen lanes increment their counter.
  - Lanes with am_v_i set their seen flag and keep counter 0.
  - A seen lane with a second am_v_i -> skew_err_o pulse, -> WAIT.
  - When the last lane is seen: offset_q <= counters (including this cycle's increment); -> LOCKED.
  - Counter at MAX_SKEW_BLOCK_N-1 needing increment while lanes are unseen -> skew_err_o pulse, -> WAIT.
- Invalid cycles hold all counters and state.
- LOCKED:
  - lock_o=1.
  - data_v_o = data_v_i registered one cycle.
  - am_v_o = AND of output am flags, qualified by data_v_o.
  - If the output am flags are not all equal on a valid output -> skew_err_o pulse, lock_o drops next cycle, -> WAIT.
  - The first locked output carries the aligned markers.
- Outside LOCKED: data_v_o=0, am_v_o=0.
- skew_zero_o[l] = (offset_q[l]==0) & lock_o.
- Simultaneous events: am_lock_i low wins over all others; an error and all-seen in the same cycle -> error wins.

Optional Feature:
AM_DROP_EN:
- Defined: data_v_o is forced 0 on cycles where am_v_o would be 1 (markers stripped, gap left to downstream), and am_v_o stays 0.
- Undefined: markers pass through with data_v_o=1 and am_v_o=1.

Test Plan:
- Markers on lanes 0,1,2,3 at valid cycles 0,3,7,1 with data_v_i=1 throughout -> offsets {7,4,0,6}, lock_o=1 on cycle 8, first output cycle shows am flags on all four lanes, am_v_o=1, skew_zero_o=4'b0100.
- All four markers in the same cycle -> lock_o next cycle, all offsets 0, skew_zero_o=4'hF, data_o equals data_i delayed 1 cycle.
- Lane 0 marker, lane 3 marker 27 valid cycles later -> skew_err_o pulse at counter 26 overflow, lock_o stays 0, state WAIT.
- Locked with offsets {2,0,1,0}, then inject an extra block on lane 1 (slip) -> output am flags mismatch at next marker, skew_err_o pulse, lock_o=0 the following cycle.
- Pauses of data_v_i=0 every 33rd cycle during ALIGN and LOCKED -> offsets are unchanged by pauses, data_v_o low one cycle after each pause, data intact.
- am_lock_i deasserted mid-ALIGN, and reset asserted while LOCKED -> WAIT, all outputs 0 next cycle; AM_DROP_EN build shows data_v_o=0 on marker cycles.

Source files
------------

// File: rtl/deskew_rx.sv
// -----------------------------------------------------------------------------
// deskew_rx - multi-lane PCS receive deskew
//
// Measures per-lane skew from alignment-marker (AM) arrival. It then delays
// every lane to the latest one through per-lane block buffers. After lock it
// keeps checking that the markers stay aligned at the output.
//
// Optional build macro:
//   AM_DROP_EN  - strip aligned markers: data_v_o is held low on marker
//                 cycles and am_v_o stays 0. When undefined, markers pass
//                 through with data_v_o=1 and am_v_o=1.
//
// Ports:
//   clk          clock
//   reset        synchronous reset, active-high
//   data_v_i     block valid on all lanes (low on gearbox pause)
//   am_v_i       per-lane alignment marker present (qualified by data_v_i)
//   am_lock_i    all lanes have alignment-marker lock
//   data_i       lane blocks, lane l at [l*BLOCK_W +: BLOCK_W]
//   data_v_o     deskewed blocks valid
//   am_v_o       aligned marker at output this cycle
//   data_o       deskewed lane blocks (zero while not locked)
//   lock_o       deskew locked
//   skew_err_o   one-cycle pulse: skew overflow or post-lock misalignment
//   skew_zero_o  lane offset is zero (latest lane[s]), only while locked
// -----------------------------------------------------------------------------
module deskew_rx #(
    parameter int LANE_N           = 4,
    parameter int BLOCK_W          = 66,
    parameter int MAX_SKEW_BIT_N   = 1856,
    parameter int MAX_SKEW_BLOCK_N = (MAX_SKEW_BIT_N - BLOCK_W - 1) / BLOCK_W,
    parameter int SKEW_CNT_W       = $clog2(MAX_SKEW_BLOCK_N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      data_v_i,
    input  logic [LANE_N-1:0]         am_v_i,
    input  logic                      am_lock_i,
    input  logic [LANE_N*BLOCK_W-1:0] data_i,
    output logic                      data_v_o,
    output logic                      am_v_o,
    output logic [LANE_N*BLOCK_W-1:0] data_o,
    output logic                      lock_o,
    output logic                      skew_err_o,
    output logic [LANE_N-1:0]         skew_zero_o
);

    typedef enum logic [1:0] {ST_WAIT, ST_ALIGN, ST_LOCKED} state_e;

    localparam logic [SKEW_CNT_W-1:0] CNT_LAST = SKEW_CNT_W'(MAX_SKEW_BLOCK_N - 1);

    state_e                             state_q, state_d;
    logic [LANE_N-1:0]                  seen_q, seen_d;
    logic [LANE_N-1:0][SKEW_CNT_W-1:0]  cnt_q, cnt_d;
    logic [LANE_N-1:0][SKEW_CNT_W-1:0]  off_q, off_d;
    logic                               data_v_q;

    // Entry 0 is the most recent block; bit BLOCK_W is the marker flag.
    logic [BLOCK_W:0] buf_q [LANE_N][MAX_SKEW_BLOCK_N];

    logic [LANE_N-1:0] out_am;
    logic              out_v;
    logic              mismatch;
    logic              err_evt;

    // ---------------------------------------------------------------- buffers
    // NOTE: the block buffers carry no reset; their contents are never read
    // until lock, and a reset would only add a wide reset fan-out.
    always_ff @(posedge clk) begin
        if (data_v_i) begin
            for (int l = 0; l < LANE_N; l++) begin
                buf_q[l][0] <= {am_v_i[l], data_i[l*BLOCK_W +: BLOCK_W]};
                for (int i = 1; i < MAX_SKEW_BLOCK_N; i++) begin
                    buf_q[l][i] <= buf_q[l][i-1];
                end
            end
        end
    end

    // Marker flags as seen at the buffer read taps.
    always_comb begin
        for (int l = 0; l < LANE_N; l++) begin
            out_am[l] = buf_q[l][off_q[l]][BLOCK_W];
        end
    end

    assign out_v    = (state_q == ST_LOCKED) && data_v_q;
    assign mismatch = !((&out_am) || !(|out_am));

    // ----------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_WAIT;
            seen_q   <= '0;
            cnt_q    <= '0;
            off_q    <= '0;
            data_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seen_q   <= seen_d;
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            data_v_q <= data_v_i;
        end
    end

    // ------------------------------------------------------------- next state
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        err_evt = 1'b0;

        if (!am_lock_i) begin
            state_d = ST_WAIT;
            seen_d  = '0;
            cnt_d   = '0;
            off_d   = '0;
        end else begin
            unique case (state_q)
                ST_WAIT: begin
                    if (data_v_i && (|am_v_i)) begin
                        seen_d  = am_v_i;
                        cnt_d   = '0;
                        off_d   = '0;
                        state_d = (&am_v_i) ? ST_LOCKED : ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (data_v_i) begin
                        for (int l = 0; l < LANE_N; l++) begin
                            if (seen_q[l]) begin
                                // A second marker before all lanes arrived, or a
                                // counter that would pass the buffer depth.
                                if (am_v_i[l] || (cnt_q[l] == CNT_LAST)) begin
                                    err_evt = 1'b1;
                                end
                                cnt_d[l] = cnt_q[l] + 1'b1;
                            end
                        end
                        seen_d = seen_q | am_v_i;
                        // An error outranks completion in the same cycle.
                        if (err_evt) begin
                            state_d = ST_WAIT;
                            seen_d  = '0;
                            cnt_d   = '0;
                            off_d   = '0;
                        end else if (&seen_d) begin
                            off_d   = cnt_d;
                            state_d = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (out_v && mismatch) begin
                        err_evt = 1'b1;
                        state_d = ST_WAIT;
                        seen_d  = '0;
                        cnt_d   = '0;
                        off_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        lock_o     = (state_q == ST_LOCKED);
        skew_err_o = err_evt;
`ifdef AM_DROP_EN
        data_v_o   = out_v && !(&out_am);
        am_v_o     = 1'b0;
`else
        data_v_o   = out_v;
        am_v_o     = out_v && (&out_am);
`endif
        data_o      = '0;
        skew_zero_o = '0;
        for (int l = 0; l < LANE_N; l++) begin
            if (lock_o) begin
                data_o[l*BLOCK_W +: BLOCK_W] = buf_q[l][off_q[l]][BLOCK_W-1:0];
                skew_zero_o[l]               = (off_q[l] == '0);
            end
        end
    end

endmodule

// File: tb/tb_deskew_rx.sv
// -----------------------------------------------------------------------------
// tb_deskew_rx - directed self-checking bench for deskew_rx.
// Inputs change on the falling edge; outputs are sampled 1 ns later, so each
// sample shows the state for the cycle whose inputs were just applied.
// -----------------------------------------------------------------------------
module tb_deskew_rx;

    localparam int LANE_N  = 4;
    localparam int BLOCK_W = 66;
    localparam int DW      = LANE_N * BLOCK_W;
`ifdef AM_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              data_v_i;
    logic [LANE_N-1:0] am_v_i;
    logic              am_lock_i;
    logic [DW-1:0]     data_i;
    logic              data_v_o;
    logic              am_v_o;
    logic [DW-1:0]     data_o;
    logic              lock_o;
    logic              skew_err_o;
    logic [LANE_N-1:0] skew_zero_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          tcnt    = 0;   // global cycle index used to tag blocks
    int          cur_idx = 0;   // valid blocks seen before the current cycle
    int          vk[$];         // cycle tag of each valid block, in order
    int          b;
    logic [3:0]  am;
    logic        v;
    logic        exp_am;
    logic        prev_v;

    deskew_rx dut (
        .clk        (clk),
        .reset      (reset),
        .data_v_i   (data_v_i),
        .am_v_i     (am_v_i),
        .am_lock_i  (am_lock_i),
        .data_i     (data_i),
        .data_v_o   (data_v_o),
        .am_v_o     (am_v_o),
        .data_o     (data_o),
        .lock_o     (lock_o),
        .skew_err_o (skew_err_o),
        .skew_zero_o(skew_zero_o)
    );

    always #5 clk = ~clk;

    function automatic logic [BLOCK_W-1:0] blk(input int l, input int k);
        logic [1:0]  ln;
        logic [31:0] hi;
        logic [31:0] lo;
        ln = 2'(l);
        hi = 32'hC0DE_0000 + 32'(k);
        lo = 32'(k * 7 + l);
        return {ln, hi, lo};
    endfunction

    // Expected output word: lane l carries the block tagged kl.
    function automatic logic [DW-1:0] word(input int k0, input int k1, input int k2, input int k3);
        return {blk(3, k3), blk(2, k2), blk(1, k1), blk(0, k0)};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_lock"}, DW'(lock_o), '0);
        check({tag, "_dv"},   DW'(data_v_o), '0);
        check({tag, "_am"},   DW'(am_v_o), '0);
        check({tag, "_err"},  DW'(skew_err_o), '0);
        check({tag, "_zero"}, DW'(skew_zero_o), '0);
        check({tag, "_data"}, data_o, '0);
    endtask

    task automatic drive(input logic dv, input logic [3:0] amv, input logic lk, input logic rst);
        @(negedge clk);
        reset     = rst;
        data_v_i  = dv;
        am_v_i    = amv;
        am_lock_i = lk;
        for (int l = 0; l < LANE_N; l++) data_i[l*BLOCK_W +: BLOCK_W] = blk(l, tcnt);
        cur_idx = vk.size();
        if (dv) vk.push_back(tcnt);
        tcnt++;
        #1;
    endtask

    initial begin
        reset = 1'b1; data_v_i = 1'b0; am_v_i = '0; am_lock_i = 1'b0; data_i = '0;
        drive(0, 4'h0, 0, 1);
        drive(0, 4'h0, 0, 1);
        drive(1, 4'h0, 1, 0);
        chk_idle("reset");

        // A: markers lanes 0,1,2,3 at cycles 0,3,7,1 -> offsets {7,4,0,6}
        b = tcnt;
        for (int k = 0; k < 8; k++) begin
            am = '0;
            am[0] = (k == 0); am[1] = (k == 3); am[2] = (k == 7); am[3] = (k == 1);
            drive(1, am, 1, 0);
            check("A_align_lock", DW'(lock_o), '0);
            check("A_align_err",  DW'(skew_err_o), '0);
        end
        drive(1, 4'h0, 1, 0);
        check("A_lock",  DW'(lock_o), DW'(1));
        check("A_zero",  DW'(skew_zero_o), DW'(4'b0100));
        check("A_data0", data_o, word(b + 0, b + 3, b + 7, b + 1));
        check("A_am0",   DW'(am_v_o), DW'(!DROP));
        check("A_dv0",   DW'(data_v_o), DW'(!DROP));
        drive(1, 4'h0, 1, 0);
        check("A_data1", data_o, word(b + 1, b + 4, b + 8, b + 2));
        check("A_dv1",   DW'(data_v_o), DW'(1));
        check("A_am1",   DW'(am_v_o), '0);
        drive(1, 4'h0, 0, 0);
        drive(1, 4'h0, 1, 0);
        chk_idle("A_unlock");

        // B: all markers together -> lock next cycle, zero offsets
        b = tcnt;
        drive(1, 4'hF, 1, 0);
        check("B_lock_early", DW'(lock_o), '0);
        drive(1, 4'h0, 1, 0);
        check("B_lock",  DW'(lock_o), DW'(1));
        check("B_zero",  DW'(skew_zero_o), DW'(4'hF));
        check("B_data0", data_o, word(b, b, b, b));
        check("B_am0",   DW'(am_v_o), DW'(!DROP));
        check("B_dv0",   DW'(data_v_o), DW'(!DROP));
        drive(1, 4'h0, 1, 0);
        check("B_data1", data_o, word(b + 1, b + 1, b + 1, b + 1));
        check("B_dv1",   DW'(data_v_o), DW'(1));
        drive(1, 4'h0, 1, 1);   // reset while locked
        drive(1, 4'h0, 1, 0);
        chk_idle("B_reset");

        // C: lane 3 marker 27 valid cycles after lane 0 -> overflow error
        for (int k = 0; k < 28; k++) begin
            am = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0110 : (k == 27) ? 4'b1000 : 4'b0000;
            drive(1, am, 1, 0);
            check("C_lock", DW'(lock_o), '0);
            if (k == 26) check("C_err_26", DW'(skew_err_o), '0);
            if (k == 27) check("C_err_27", DW'(skew_err_o), DW'(1));
        end
        drive(1, 4'hF, 1, 0);   // WAIT accepts a fresh all-lane marker
        check("C_after_err", DW'(skew_err_o), '0);
        check("C_after_lock", DW'(lock_o), '0);
        drive(1, 4'h0, 1, 0);
        check("C_relock", DW'(lock_o), DW'(1));
        check("C_zero",   DW'(skew_zero_o), DW'(4'hF));

        // E: second marker on an already seen lane during ALIGN
        drive(1, 4'h0, 0, 0);
        drive(1, 4'b0001, 1, 0);
        drive(1, 4'b0000, 1, 0);
        drive(1, 4'b0001, 1, 0);
        check("E_err", DW'(skew_err_o), DW'(1));
        drive(1, 4'b0000, 1, 0);
        check("E_lock", DW'(lock_o), '0);
        check("E_err_clr", DW'(skew_err_o), '0);

        // D: offsets {2,0,1,0}, lane 1 marker slips one block
        b = tcnt;
        for (int k = 0; k < 15; k++) begin
            case (k)
                0, 10:   am = 4'b0001;
                1, 11:   am = 4'b0100;
                2:       am = 4'b1010;
                12:      am = 4'b1000;
                13:      am = 4'b0010;
                default: am = 4'b0000;
            endcase
            drive(1, am, 1, 0);
            if (k == 3) begin
                check("D_lock", DW'(lock_o), DW'(1));
                check("D_zero", DW'(skew_zero_o), DW'(4'b1010));
                check("D_data", data_o, word(b + 0, b + 2, b + 1, b + 2));
                check("D_am",   DW'(am_v_o), DW'(!DROP));
            end
            if (k == 12) check("D_err_12", DW'(skew_err_o), '0);
            if (k == 13) check("D_err_13", DW'(skew_err_o), DW'(1));
            if (k == 14) check("D_unlock", DW'(lock_o), '0);
        end

        // G: am_lock_i drops mid-ALIGN
        drive(1, 4'b0001, 1, 0);
        drive(1, 4'b0000, 0, 0);
        check("G_lock_drop", DW'(lock_o), '0);
        drive(1, 4'hF, 1, 0);
        chk_idle("G_wait");
        drive(1, 4'h0, 1, 0);
        check("G_relock", DW'(lock_o), DW'(1));
        check("G_zero",   DW'(skew_zero_o), DW'(4'hF));

        // F: pause every 33rd cycle in ALIGN and LOCKED -> offsets {3,2,0,3}
        drive(1, 4'h0, 0, 0);
        for (int k = 0; k < 102; k++) begin
            v = ((k % 33) != 32);
            prev_v = (((k - 1) % 33) != 32);
            case (k)
                30, 95:  am = 4'b1001;
                31, 96:  am = 4'b0010;
                34, 99:  am = 4'b0100;
                default: am = 4'b0000;
            endcase
            drive(v, am, 1, 0);
            check("F_err", DW'(skew_err_o), '0);
            if (k < 35) begin
                check("F_align_lock", DW'(lock_o), '0);
            end else begin
                exp_am = (k == 35) || (k == 100);
                check("F_lock", DW'(lock_o), DW'(1));
                check("F_dv",   DW'(data_v_o), DW'(prev_v && !(DROP && exp_am)));
                check("F_am",   DW'(am_v_o), DW'(exp_am && !DROP));
                if (k == 35) check("F_zero", DW'(skew_zero_o), DW'(4'b0100));
                if (prev_v)
                    check("F_data", data_o, word(vk[cur_idx - 4], vk[cur_idx - 3],
                                                 vk[cur_idx - 1], vk[cur_idx - 4]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
